// File: rtl/cic_sched_pkg.sv
// Shared types and default sizes for the interpolating-CIC sequencer.
// Imported by the interface, the sample FIFO and the top level.
package cic_sched_pkg;

   localparam int CIC_IBITS   = 20;
   localparam int CIC_DIVBITS = 16;
   localparam int CIC_DEPTH   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [CIC_IBITS-1:0] re;
      logic [CIC_IBITS-1:0] im;
   } cplx_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/cic_interp_sched_if.sv
// Sample handshake between the polyphase FIR, the sequencer and the CIC input port.
// The slave modport is the sequencer side; master is the surrounding datapath.
interface cic_interp_sched_if
   import cic_sched_pkg::*;
#(
   parameter int IBITS = CIC_IBITS
);
   logic             up_valid;
   logic             up_ready;
   logic [IBITS-1:0] up_real;
   logic [IBITS-1:0] up_imag;
   logic             cic_en;
   logic             cic_req;
   logic [IBITS-1:0] cic_x_real;
   logic [IBITS-1:0] cic_x_imag;

   modport slave (
      input  up_valid, up_real, up_imag, cic_req,
      output up_ready, cic_en, cic_x_real, cic_x_imag
   );

   modport master (
      output up_valid, up_real, up_imag, cic_req,
      input  up_ready, cic_en, cic_x_real, cic_x_imag
   );
endinterface

// File: rtl/cic_sched_fifo.sv
// DEPTH-entry FIFO of packed complex samples; head is presented combinationally.
// Flush empties it in one cycle; push when full and pop when empty are ignored.
module cic_sched_fifo
   import cic_sched_pkg::*;
#(
   parameter int WIDTH = 2 * CIC_IBITS,
   parameter int DEPTH = CIC_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cic_interp_sched.sv
// Sequencer for the order-5 interpolating CIC: rate enable, sample buffer and underrun flagging.
// Optional build macro CIC_SCHED_UNDERRUN_CNT_EN adds the saturating underrun event counter.
module cic_interp_sched
   import cic_sched_pkg::*;
#(
   parameter int IBITS   = CIC_IBITS,
   parameter int DIVBITS = CIC_DIVBITS,
   parameter int DEPTH   = CIC_DEPTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic [DIVBITS-1:0] div_m1,
   cic_interp_sched_if.slave  bus,
   output logic               underrun,
   output logic [15:0]        underrun_cnt
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   sched_state_t       state;
   logic [DIVBITS-1:0] div_lat;
   logic [DIVBITS-1:0] div_cnt;
   logic               cic_en_q;
   logic [IBITS-1:0]   x_real_q;
   logic [IBITS-1:0]   x_imag_q;
   logic [2*IBITS-1:0] head;
   logic [AW:0]        count;
   logic               empty;
   logic               full;
   logic               flush;
   logic               push;
   logic               pop;
   logic               req_run;

   // Dropping run discards the buffer on the same edge that returns the FSM to IDLE.
   assign req_run      = (state == RUN) && run && bus.cic_req;
   assign flush        = (state == IDLE) || !run;
   assign push         = bus.up_valid && bus.up_ready && !flush;
   assign pop          = !flush && (((state == PRIME) && full) || (req_run && !empty));
   assign bus.up_ready = (count < DEPTH_CNT);

   cic_sched_fifo #(
      .WIDTH (2 * IBITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   ({bus.up_real, bus.up_imag}),
      .head  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         div_lat  <= '0;
         div_cnt  <= '0;
         cic_en_q <= 1'b0;
         x_real_q <= '0;
         x_imag_q <= '0;
         underrun <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cic_en_q <= 1'b0;
               x_real_q <= '0;
               x_imag_q <= '0;
               underrun <= 1'b0;
               div_cnt  <= '0;
               if (run) begin
                  div_lat <= div_m1;
                  state   <= PRIME;
               end
            end
            PRIME: begin
               cic_en_q <= 1'b0;
               if (!run) begin
                  x_real_q <= '0;
                  x_imag_q <= '0;
                  state    <= IDLE;
               end else if (full) begin
                  x_real_q <= head[2*IBITS-1:IBITS];
                  x_imag_q <= head[IBITS-1:0];
                  div_cnt  <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!run) begin
                  cic_en_q <= 1'b0;
                  x_real_q <= '0;
                  x_imag_q <= '0;
                  div_cnt  <= '0;
                  state    <= IDLE;
               end else begin
                  if (div_cnt == div_lat) begin
                     div_cnt  <= '0;
                     cic_en_q <= 1'b1;
                  end else begin
                     div_cnt  <= div_cnt + DIVBITS'(1);
                     cic_en_q <= 1'b0;
                  end
                  // An empty buffer zero-stuffs rather than repeating the stale sample.
                  if (bus.cic_req) begin
                     if (empty) begin
                        x_real_q <= '0;
                        x_imag_q <= '0;
                        underrun <= 1'b1;
                     end else begin
                        x_real_q <= head[2*IBITS-1:IBITS];
                        x_imag_q <= head[IBITS-1:0];
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cic_en     = cic_en_q;
   assign bus.cic_x_real = x_real_q;
   assign bus.cic_x_imag = x_imag_q;

`ifdef CIC_SCHED_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ucnt_q <= '0;
      end else if (req_run && empty) begin
         ucnt_q <= sat_inc16(ucnt_q);
      end
   end

   assign underrun_cnt = ucnt_q;
`else
   assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cic_interp_sched.sv
// Directed bench for cic_interp_sched: a cycle table for the basic flow plus hand-written
// sequences for reset, rate timing, CIC-paced ordering, underrun, full-buffer and restart cases.
module tb_cic_interp_sched;
   import cic_sched_pkg::*;

   localparam int IBITS   = CIC_IBITS;
   localparam int DIVBITS = CIC_DIVBITS;
`ifdef CIC_SCHED_UNDERRUN_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               run   = 1'b0;
   logic [DIVBITS-1:0] div_m1 = '0;
   logic               underrun;
   logic [15:0]        underrun_cnt;

   int numChecks = 0;
   int numFails  = 0;

   cic_interp_sched_if #(.IBITS(IBITS)) bus ();

   cic_interp_sched #(
      .IBITS   (IBITS),
      .DIVBITS (DIVBITS),
      .DEPTH   (CIC_DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .div_m1       (div_m1),
      .bus          (bus),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic               run;
      logic [DIVBITS-1:0] div;
      logic               valid;
      cplx_t              din;
      logic               req;
      logic               ready;
      logic               en;
      cplx_t              x;
      logic               und;
      logic [15:0]        ucnt;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(int r, int d, int v, int dr, int di, int q,
                               int rdy, int en, int xr, int xi, int u, int uc);
      vec_t t;
      t.run    = (r != 0);
      t.div    = DIVBITS'(d);
      t.valid  = (v != 0);
      t.din.re = IBITS'(dr);
      t.din.im = IBITS'(di);
      t.req    = (q != 0);
      t.ready  = (rdy != 0);
      t.en     = (en != 0);
      t.x.re   = IBITS'(xr);
      t.x.im   = IBITS'(xi);
      t.und    = (u != 0);
      t.ucnt   = 16'(uc);
      return t;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      run          = v.run;
      div_m1       = v.div;
      bus.up_valid = v.valid;
      bus.up_real  = v.din.re;
      bus.up_imag  = v.din.im;
      bus.cic_req  = v.req;
      tick();
   endtask

   task automatic pushOne(input int re);
      bus.up_valid = 1'b1;
      bus.up_real  = IBITS'(re);
      bus.up_imag  = IBITS'(re + 'h100);
      tick();
   endtask

   task automatic checkX(input string name, input int re);
      checkOutput({name, "_x_real"}, int'(bus.cic_x_real), re);
      checkOutput({name, "_x_imag"}, int'(bus.cic_x_imag), (re == 0) ? 0 : re + 'h100);
   endtask

   task automatic measurePulses(input string tag, input int period, input int nPulses);
      int pulses = 0;
      for (int c = 1; c <= period * nPulses; c++) begin
         tick();
         if (bus.cic_en === 1'b1) begin
            checkOutput({tag, "_pulse_cycle"}, c, period * (pulses + 1));
            pulses++;
         end
      end
      checkOutput({tag, "_pulse_count"}, pulses, nPulses);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = mk(1, 1, 0, 0,    0,    0, 1, 0, 0,    0,    0, 0);
      vecs[1]  = mk(1, 1, 1, 'h11, 'h21, 0, 1, 0, 0,    0,    0, 0);
      vecs[2]  = mk(1, 1, 1, 'h12, 'h22, 0, 0, 0, 0,    0,    0, 0);
      vecs[3]  = mk(1, 1, 1, 'h13, 'h23, 0, 1, 0, 'h11, 'h21, 0, 0);
      vecs[4]  = mk(1, 1, 1, 'h13, 'h23, 0, 0, 0, 'h11, 'h21, 0, 0);
      vecs[5]  = mk(1, 1, 0, 0,    0,    0, 0, 1, 'h11, 'h21, 0, 0);
      vecs[6]  = mk(1, 1, 0, 0,    0,    1, 1, 0, 'h12, 'h22, 0, 0);
      vecs[7]  = mk(1, 1, 0, 0,    0,    0, 1, 1, 'h12, 'h22, 0, 0);
      vecs[8]  = mk(1, 1, 1, 'h14, 'h24, 1, 1, 0, 'h13, 'h23, 0, 0);
      vecs[9]  = mk(1, 1, 0, 0,    0,    1, 1, 1, 'h14, 'h24, 0, 0);
      vecs[10] = mk(1, 1, 0, 0,    0,    1, 1, 0, 0,    0,    1, 1);
      vecs[11] = mk(1, 1, 1, 'h15, 'h25, 0, 1, 1, 0,    0,    1, 1);
      vecs[12] = mk(1, 1, 0, 0,    0,    1, 1, 0, 'h15, 'h25, 1, 1);
      vecs[13] = mk(0, 1, 0, 0,    0,    0, 1, 0, 0,    0,    1, 1);
      vecs[14] = mk(0, 1, 0, 0,    0,    0, 1, 0, 0,    0,    0, 1);

      bus.up_valid = 1'b0;
      bus.up_real  = '0;
      bus.up_imag  = '0;
      bus.cic_req  = 1'b0;
      reset        = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      checkOutput("rst_cic_en", int'(bus.cic_en), 0);
      checkX("rst", 0);
      checkOutput("rst_underrun", int'(underrun), 0);
      checkOutput("rst_underrun_cnt", int'(underrun_cnt), 0);
      checkOutput("rst_up_ready", int'(bus.up_ready), 1);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_up_ready", i), int'(bus.up_ready), int'(vecs[i].ready));
         checkOutput($sformatf("vec%0d_cic_en", i), int'(bus.cic_en), int'(vecs[i].en));
         checkOutput($sformatf("vec%0d_x_real", i), int'(bus.cic_x_real), int'(vecs[i].x.re));
         checkOutput($sformatf("vec%0d_x_imag", i), int'(bus.cic_x_imag), int'(vecs[i].x.im));
         checkOutput($sformatf("vec%0d_underrun", i), int'(underrun), int'(vecs[i].und));
         checkOutput($sformatf("vec%0d_underrun_cnt", i), int'(underrun_cnt),
                     CNT_ON ? int'(vecs[i].ucnt) : 0);
      end

      // Reset asserted mid-cycle while running with a set underrun flag.
      bus.up_valid = 1'b0;
      bus.cic_req  = 1'b0;
      div_m1 = DIVBITS'(0);
      run    = 1'b1;
      tick();
      pushOne('h71);
      pushOne('h72);
      bus.up_valid = 1'b0;
      tick();
      bus.cic_req = 1'b1;
      tick();
      tick();
      bus.cic_req = 1'b0;
      checkOutput("t1_pre_en", int'(bus.cic_en), 1);
      checkOutput("t1_pre_underrun", int'(underrun), 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("t1_async_cic_en", int'(bus.cic_en), 0);
      checkX("t1_async", 0);
      checkOutput("t1_async_underrun", int'(underrun), 0);
      checkOutput("t1_async_underrun_cnt", int'(underrun_cnt), 0);
      run = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      checkOutput("t1_up_ready_after", int'(bus.up_ready), 1);
      checkOutput("t1_cic_en_after", int'(bus.cic_en), 0);

      // Rate period 8 with two preloaded samples.
      div_m1 = DIVBITS'(7);
      run    = 1'b1;
      tick();
      pushOne('hA1);
      pushOne('hA2);
      bus.up_valid = 1'b0;
      tick();
      checkX("t2_first", 'hA1);
      checkOutput("t2_first_en", int'(bus.cic_en), 0);
      measurePulses("t2", 8, 4);

      // CIC model with R=4 pacing req; upstream pushes 1..10 whenever ready.
      run = 1'b0;
      tick();
      tick();
      div_m1 = DIVBITS'(1);
      run    = 1'b1;
      tick();
      begin : t3
         int q[$];
         int nxt    = 1;
         int reqs   = 0;
         int enCnt  = 0;
         int modelX = 0;
         bit primed = 1'b0;
         bit reqNow;
         bit accept;
         for (int c = 0; c < 400 && reqs < 9; c++) begin
            reqNow = primed && (enCnt >= 4);
            if (reqNow) enCnt = 0;
            bus.cic_req  = reqNow;
            bus.up_valid = (nxt <= 10);
            bus.up_real  = IBITS'(nxt);
            bus.up_imag  = IBITS'(nxt + 'h100);
            accept = bus.up_valid && bus.up_ready;
            tick();
            if (!primed && bus.cic_x_real == IBITS'(1)) begin
               primed = 1'b1;
               modelX = q.pop_front();
            end else if (reqNow) begin
               modelX = (q.size() > 0) ? q.pop_front() : 0;
               reqs++;
            end
            if (accept) begin
               q.push_back(nxt);
               nxt++;
            end
            if (primed) checkX($sformatf("t3_cycle%0d", c), modelX);
            if (bus.cic_en === 1'b1) enCnt++;
         end
         checkOutput("t3_primed", int'(primed), 1);
         checkOutput("t3_req_count", reqs, 9);
         checkOutput("t3_last_x", int'(bus.cic_x_real), 10);
      end

      // Upstream stalled: next request underruns.
      bus.up_valid = 1'b0;
      bus.cic_req  = 1'b0;
      tick();
      checkOutput("t4_underrun_before", int'(underrun), 0);
      bus.cic_req = 1'b1;
      tick();
      bus.cic_req = 1'b0;
      checkX("t4", 0);
      checkOutput("t4_underrun", int'(underrun), 1);
      checkOutput("t4_underrun_cnt", int'(underrun_cnt), CNT_ON ? 1 : 0);

      // Full buffer with upstream held valid across pops.
      run = 1'b0;
      tick();
      tick();
      checkOutput("t5_underrun_cleared", int'(underrun), 0);
      div_m1 = DIVBITS'(0);
      run    = 1'b1;
      tick();
      pushOne('h51);
      pushOne('h52);
      pushOne('h53);
      checkX("t5_prime", 'h51);
      checkOutput("t5_prime_ready", int'(bus.up_ready), 1);
      pushOne('h53);
      checkOutput("t5_full_ready", int'(bus.up_ready), 0);
      bus.cic_req = 1'b1;
      pushOne('h54);
      checkX("t5_a", 'h52);
      checkOutput("t5_a_ready", int'(bus.up_ready), 1);
      bus.cic_req = 1'b0;
      pushOne('h54);
      checkX("t5_b", 'h52);
      checkOutput("t5_b_ready", int'(bus.up_ready), 0);
      bus.cic_req = 1'b1;
      pushOne('h55);
      checkX("t5_c", 'h53);
      checkOutput("t5_c_ready", int'(bus.up_ready), 1);
      pushOne('h55);
      checkX("t5_d", 'h54);
      checkOutput("t5_d_ready", int'(bus.up_ready), 1);
      bus.up_valid = 1'b0;
      tick();
      checkX("t5_e", 'h55);
      tick();
      bus.cic_req = 1'b0;
      checkX("t5_f", 0);
      checkOutput("t5_f_underrun", int'(underrun), 1);
      checkOutput("t5_f_underrun_cnt", int'(underrun_cnt), CNT_ON ? 2 : 0);

      // Abort with a buffered sample, then restart at period 4.
      pushOne('h66);
      bus.up_valid = 1'b0;
      run = 1'b0;
      tick();
      checkOutput("t6_abort_en", int'(bus.cic_en), 0);
      checkX("t6_abort", 0);
      tick();
      checkOutput("t6_idle_underrun", int'(underrun), 0);
      checkOutput("t6_idle_ready", int'(bus.up_ready), 1);
      checkOutput("t6_idle_en", int'(bus.cic_en), 0);
      div_m1 = DIVBITS'(3);
      run    = 1'b1;
      tick();
      div_m1 = DIVBITS'(9);
      pushOne('h61);
      pushOne('h62);
      bus.up_valid = 1'b0;
      tick();
      checkX("t6_first", 'h61);
      measurePulses("t6", 4, 4);

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
      $finish;
   end

endmodule
